cmd_sequencer: RTL and testbench

- Parametrised successor to the calculator command control FSM.
- Counts incoming characters from the RX path and detects the terminator.
- Sequences input-queue clear, an ALU start/done handshake, and output transmission.
- Adds overflow detection, an abort character, ALU error reporting and an error-report path. Sits between the UART RX queue, the ALU and the TX formatter.

---
 rtl/cmd_sequencer.sv | 157 +++++++++++++++
 tb/tb_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_sequencer.sv
// rtl/cmd_sequencer.sv - command sequencer: counts RX chars, runs ALU handshake, drives TX/error report
//
// Optional feature macro: CMD_SEQ_TIMEOUT_EN (ALU wait timeout, err_code 11)
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   rx_valid, rx_char   received character strobe and data
//   alu_done, alu_err   ALU completion and error qualifier
//   sent                TX formatter finished sending result / error message
//   iq_rst              clear input queue (CLEAR)
//   alu_en              ALU start pulse (EXEC)
//   out_en              TX formatter enable (OUTPUT, ERROR)
//   err                 error report active (ERROR)
//   err_code            00 none, 01 overflow, 10 ALU, 11 timeout
//   char_cnt            payload characters accepted
//   state               current state, for debug
module cmd_sequencer #(
    parameter int                CHAR_W      = 8,
    parameter int                DEPTH       = 15,
    parameter logic [CHAR_W-1:0] TERM        = 8'h0D,
    parameter logic [CHAR_W-1:0] ABORT       = 8'h1B,
    parameter int                TIMEOUT_CYC = 1000000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx_valid,
    input  logic [CHAR_W-1:0]          rx_char,
    input  logic                       alu_done,
    input  logic                       alu_err,
    input  logic                       sent,
    output logic                       iq_rst,
    output logic                       alu_en,
    output logic                       out_en,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [$clog2(DEPTH+1)-1:0] char_cnt,
    output logic [2:0]                 state
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        S_CLEAR    = 3'b000,
        S_COLLECT  = 3'b001,
        S_EXEC     = 3'b010,
        S_WAIT_ALU = 3'b011,
        S_OUTPUT   = 3'b100,
        S_ERROR    = 3'b101
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_char_cnt;
    logic [CNT_W-1:0]   w_char_cnt_nxt;
    logic [1:0]         r_err_code;
    logic [1:0]         w_err_code_nxt;
    logic               w_timeout;

`ifdef CMD_SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] r_to_cnt;

    // Held at zero outside WAIT_ALU so it always starts from zero on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != S_WAIT_ALU) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    logic w_unused_timeout_cyc;
    assign w_unused_timeout_cyc = (TIMEOUT_CYC != 0);
    assign w_timeout            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_CLEAR;
            r_char_cnt <= '0;
            r_err_code <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_char_cnt <= w_char_cnt_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_char_cnt_nxt = r_char_cnt;
        w_err_code_nxt = r_err_code;
        case (r_state)
            S_CLEAR: begin
                w_state_nxt    = S_COLLECT;
                w_char_cnt_nxt = '0;
                w_err_code_nxt = 2'b00;
            end
            S_COLLECT: begin
                if (rx_valid) begin
                    if (rx_char == ABORT) begin
                        w_state_nxt = S_CLEAR;
                    end else if (rx_char == TERM && r_char_cnt == '0) begin
                        // Empty line: nothing to compute.
                        w_state_nxt = S_CLEAR;
                    end else if (rx_char == TERM) begin
                        w_state_nxt = S_EXEC;
                    end else if (r_char_cnt == CNT_W'(DEPTH)) begin
                        w_state_nxt    = S_ERROR;
                        w_err_code_nxt = 2'b01;
                    end else begin
                        w_char_cnt_nxt = r_char_cnt + 1'b1;
                    end
                end
            end
            S_EXEC: begin
                w_state_nxt = S_WAIT_ALU;
            end
            S_WAIT_ALU: begin
                // alu_done outranks a timeout landing in the same cycle.
                if (alu_done) begin
                    if (alu_err) begin
                        w_state_nxt    = S_ERROR;
                        w_err_code_nxt = 2'b10;
                    end else begin
                        w_state_nxt = S_OUTPUT;
                    end
                end else if (w_timeout) begin
                    w_state_nxt    = S_ERROR;
                    w_err_code_nxt = 2'b11;
                end
            end
            S_OUTPUT, S_ERROR: begin
                if (sent) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    assign iq_rst   = (r_state == S_CLEAR);
    assign alu_en   = (r_state == S_EXEC);
    assign out_en   = (r_state == S_OUTPUT) || (r_state == S_ERROR);
    assign err      = (r_state == S_ERROR);
    assign err_code = r_err_code;
    assign char_cnt = r_char_cnt;
    assign state    = r_state;

endmodule

// File: tb/tb_cmd_sequencer.sv
// tb/tb_cmd_sequencer.sv - self-checking bench for cmd_sequencer
module tb_cmd_sequencer;

    localparam int         DEPTH = 15;
    localparam logic [7:0] TERM  = 8'h0D;
    localparam logic [7:0] ABORT = 8'h1B;

    localparam logic [2:0] ST_CLEAR   = 3'b000;
    localparam logic [2:0] ST_COLLECT = 3'b001;
    localparam logic [2:0] ST_EXEC    = 3'b010;
    localparam logic [2:0] ST_WAIT    = 3'b011;
    localparam logic [2:0] ST_OUTPUT  = 3'b100;
    localparam logic [2:0] ST_ERROR   = 3'b101;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_char  = 8'h00;
    logic       alu_done = 1'b0;
    logic       alu_err  = 1'b0;
    logic       sent     = 1'b0;
    logic       iq_rst;
    logic       alu_en;
    logic       out_en;
    logic       err;
    logic [1:0] err_code;
    logic [3:0] char_cnt;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    logic [7:0] cmd_q[$];

    cmd_sequencer #(
        .CHAR_W     (8),
        .DEPTH      (DEPTH),
        .TERM       (TERM),
        .ABORT      (ABORT),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_valid(rx_valid),
        .rx_char (rx_char),
        .alu_done(alu_done),
        .alu_err (alu_err),
        .sent    (sent),
        .iq_rst  (iq_rst),
        .alu_en  (alu_en),
        .out_en  (out_en),
        .err     (err),
        .err_code(err_code),
        .char_cnt(char_cnt),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] st);
        check({tag, ".state"},  32'(state),  32'(st));
        check({tag, ".iq_rst"}, 32'(iq_rst), 32'(st == ST_CLEAR));
        check({tag, ".alu_en"}, 32'(alu_en), 32'(st == ST_EXEC));
        check({tag, ".out_en"}, 32'(out_en), 32'(st == ST_OUTPUT || st == ST_ERROR));
        check({tag, ".err"},    32'(err),    32'(st == ST_ERROR));
    endtask

    // Cycles where the sequencer must not move; RX noise must be ignored outside COLLECT.
    task automatic hold_wait(input int n, input logic [2:0] st, input int cnt, input logic [1:0] ec);
        for (int k = 0; k < n; k++) begin
            if (st != ST_COLLECT) begin
                rx_valid = 1'($urandom % 2);
                rx_char  = ($urandom % 3 == 0) ? TERM : 8'(8'h30 + $urandom % 10);
            end
            tick();
            rx_valid = 1'b0;
            check("hold.state", 32'(state), 32'(st));
            check("hold.cnt", 32'(char_cnt), 32'(cnt));
            check("hold.ec", 32'(err_code), 32'(ec));
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        rx_char  = c;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic finish_report(input logic [1:0] ec, input int cnt, input logic is_err);
        logic [2:0] st;
        st = is_err ? ST_ERROR : ST_OUTPUT;
        check_outputs("report", st);
        check("report.ec", 32'(err_code), 32'(ec));
        check("report.cnt", 32'(char_cnt), 32'(cnt));
        hold_wait($urandom_range(0, 3), st, cnt, ec);
        sent = 1'b1;
        tick();
        sent = 1'b0;
        check_outputs("sent", ST_CLEAR);
        tick();
        check_outputs("after_clear", ST_COLLECT);
        check("after_clear.cnt", 32'(char_cnt), 0);
        check("after_clear.ec", 32'(err_code), 0);
    endtask

    // mode 0: ALU answers after delay; 1: ALU never answers; 2: reset during the wait
    task automatic alu_phase(input int cnt, input logic e, input int delay, input int mode);
        if (mode == 1) begin
`ifdef CMD_SEQ_TIMEOUT_EN
            hold_wait(15, ST_WAIT, cnt, 2'b00);
            tick();
            finish_report(2'b11, cnt, 1'b1);
`else
            hold_wait(40, ST_WAIT, cnt, 2'b00);
            alu_done = 1'b1;
            tick();
            alu_done = 1'b0;
            finish_report(2'b00, cnt, 1'b0);
`endif
        end else if (mode == 2) begin
            hold_wait(3, ST_WAIT, cnt, 2'b00);
            #2 rst_n = 1'b0;
            #1;
            check_outputs("async_rst", ST_CLEAR);
            check("async_rst.cnt", 32'(char_cnt), 0);
            check("async_rst.ec", 32'(err_code), 0);
            repeat (2) @(posedge clk);
            #1;
            check_outputs("in_rst", ST_CLEAR);
            rst_n = 1'b1;
            tick();
            check_outputs("rst_release", ST_COLLECT);
        end else begin
            hold_wait(delay, ST_WAIT, cnt, 2'b00);
            alu_done = 1'b1;
            alu_err  = e;
            tick();
            alu_done = 1'b0;
            alu_err  = 1'b0;
            finish_report(e ? 2'b10 : 2'b00, cnt, e);
        end
    endtask

    // Reference model: walk cmd_q with the command rules, starting in COLLECT with zero chars.
    task automatic run_cmd(input logic e, input int delay, input logic exec_noise, input int mode);
        int cnt;
        cnt = 0;
        foreach (cmd_q[i]) begin
            hold_wait($urandom_range(0, 2), ST_COLLECT, cnt, 2'b00);
            send_char(cmd_q[i]);
            if (cmd_q[i] == ABORT) begin
                check_outputs("abort", ST_CLEAR);
                tick();
                check_outputs("abort_next", ST_COLLECT);
                check("abort_next.cnt", 32'(char_cnt), 0);
                cnt = 0;
            end else if (cmd_q[i] == TERM && cnt == 0) begin
                check_outputs("empty", ST_CLEAR);
                tick();
                check_outputs("empty_next", ST_COLLECT);
            end else if (cmd_q[i] == TERM) begin
                check_outputs("exec", ST_EXEC);
                check("exec.cnt", 32'(char_cnt), 32'(cnt));
                alu_done = exec_noise;
                alu_err  = exec_noise;
                tick();
                alu_done = 1'b0;
                alu_err  = 1'b0;
                check_outputs("wait_entry", ST_WAIT);
                check("wait_entry.cnt", 32'(char_cnt), 32'(cnt));
                alu_phase(cnt, e, delay, mode);
                return;
            end else if (cnt == DEPTH) begin
                finish_report(2'b01, cnt, 1'b1);
                return;
            end else begin
                cnt++;
                check("collect.cnt", 32'(char_cnt), 32'(cnt));
                check("collect.state", 32'(state), 32'(ST_COLLECT));
            end
        end
    endtask

    task automatic load(input string s);
        cmd_q.delete();
        for (int k = 0; k < s.len(); k++) cmd_q.push_back(s[k]);
    endtask

    initial begin
        // Reset state
        #3;
        check_outputs("reset", ST_CLEAR);
        check("reset.cnt", 32'(char_cnt), 0);
        check("reset.ec", 32'(err_code), 0);
        rx_valid = 1'b1;
        rx_char  = 8'h31;
        tick();
        tick();
        rx_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        check_outputs("release", ST_COLLECT);
        check("release.cnt", 32'(char_cnt), 0);

        // Normal command "1+2\r"
        load("1+2");
        cmd_q.push_back(TERM);
        run_cmd(1'b0, 2, 1'b0, 0);

        // sent outside OUTPUT/ERROR is ignored
        sent = 1'b1;
        tick();
        sent = 1'b0;
        check_outputs("sent_ignored", ST_COLLECT);

        // Overflow: 16 nines
        load("9999999999999999");
        run_cmd(1'b0, 0, 1'b0, 0);

        // Abort then short command
        load("55");
        cmd_q.push_back(ABORT);
        cmd_q.push_back(8'h33);
        cmd_q.push_back(TERM);
        run_cmd(1'b0, 1, 1'b0, 0);

        // Empty line
        cmd_q.delete();
        cmd_q.push_back(TERM);
        run_cmd(1'b0, 0, 1'b0, 0);

        // ALU error, with alu_done raised during EXEC
        load("7*8");
        cmd_q.push_back(TERM);
        run_cmd(1'b1, 2, 1'b1, 0);

        // ALU never answers (timeout or indefinite wait)
        load("42");
        cmd_q.push_back(TERM);
        run_cmd(1'b0, 0, 1'b0, 1);

        // Reset while waiting on ALU
        load("6/3");
        cmd_q.push_back(TERM);
        run_cmd(1'b0, 0, 1'b0, 2);

        // Randomized commands
        for (int n = 0; n < 40; n++) begin
            int len;
            cmd_q.delete();
            len = $urandom_range(0, 18);
            for (int k = 0; k < len; k++) begin
                if ($urandom % 20 == 0) cmd_q.push_back(ABORT);
                else cmd_q.push_back(8'(8'h30 + $urandom % 10));
            end
            cmd_q.push_back(TERM);
            run_cmd(1'($urandom % 2), $urandom_range(0, 4), 1'($urandom % 2), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
